gppcu_wb_arbiter: RTL and testbench
===================================

GPPCU_WB_ARBITER -- requirements
Module: gppcu_wb_arbiter

Interface
REQ-001 The block SHALL have parameter NUMREG, default 32: number of architectural registers.
REQ-002 The block SHALL have parameter REGW, default 5: register index width, equal to ceil(log2(NUMREG)).
REQ-003 The block SHALL have parameter DATAW, default 32: writeback data width.
REQ-004 The block SHALL have parameter NREQ, default 3: number of requesters, for example ALU, MUL and LSU.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-006 The block SHALL have the following ports, clock and reset first:
- iACLK  in  1: clock; all state updates on the rising edge.
- iRST  in  1: asynchronous reset, active-high.
- iREQ_VALID  in  NREQ: bit k high means requester k presents a writeback.
- iREQ_REG  in  NREQ*REGW: destination register index; slice k belongs to requester k.
- iREQ_DATA  in  NREQ*DATAW: writeback data; slice k belongs to requester k.
- oREQ_READY  out  NREQ: bit k high means requester k's writeback is accepted this cycle.
- iWB_STALL  in  1: register-file write port is unavailable this cycle.
- oWB_VALID  out  1: registered writeback strobe to the register file and the stall generator.
- oWB_REG  out  REGW: registered destination register index.
- oWB_DATA  out  DATAW: registered writeback data.
- oWB_COUNT  out  16: count of completed writebacks.
- oDUP_ERR  out  1: sticky flag for a destination collision.

Function
REQ-007 A transfer on requester k SHALL occur in a cycle where iREQ_VALID[k] and oREQ_READY[k] are both high.
REQ-008 At most one oREQ_READY bit SHALL be high in any cycle.
REQ-009 oREQ_READY SHALL be a combinational function of iREQ_VALID, the round-robin pointer, oWB_VALID and iWB_STALL.
REQ-010 The output stage SHALL be free when oWB_VALID is low or iWB_STALL is low.
REQ-011 oREQ_READY SHALL be all zero while the output stage is not free.
REQ-012 When the output stage is free, the grant SHALL go to the first valid requester found searching upward from pointer PTR, wrapping at NREQ-1 back to 0.
REQ-013 On a transfer from requester g, PTR SHALL update to g+1, or to 0 when g equals NREQ-1.
REQ-014 PTR SHALL be unchanged in any cycle with no transfer.
REQ-015 On a transfer, the output register SHALL load the granted requester's REG and DATA slices on the next edge and set oWB_VALID, giving a latency of one cycle.
REQ-016 The writeback in the output register SHALL complete at an edge where oWB_VALID is high and iWB_STALL is low.
REQ-017 When a writeback completes with no new transfer, oWB_VALID SHALL clear.
REQ-018 When a writeback completes and a new transfer occurs in the same cycle, the output register SHALL reload, so back-to-back throughput is one writeback per cycle.
REQ-019 While oWB_VALID is high and iWB_STALL is high, oWB_VALID, oWB_REG and oWB_DATA SHALL hold their values.
REQ-020 oWB_COUNT SHALL increment by 1 on each completed writeback.
REQ-021 oWB_COUNT SHALL wrap from 0xFFFF to 0x0000.
REQ-022 oDUP_ERR SHALL set on the next edge when two or more requesters are valid in the same cycle with equal register indices.
REQ-023 Once set, oDUP_ERR SHALL remain high until reset.
REQ-024 Arbitration SHALL NOT be affected by a destination collision.
REQ-025 A requester that drops iREQ_VALID without being granted SHALL lose no state in the block.
REQ-026 Requester payload need not be held stable before a grant; the block samples it only on the transfer cycle.

Reset
REQ-027 While iRST is high, oWB_VALID, oWB_REG, oWB_DATA, oWB_COUNT, oDUP_ERR and PTR SHALL be 0, regardless of iACLK.
REQ-028 oREQ_READY SHALL be 0 while iRST is high.
REQ-029 Assertion of iRST mid-writeback, including while stalled, SHALL discard the pending writeback without completing it.
REQ-030 The first grant after reset release SHALL follow REQ-012 with PTR equal to 0.

Verification
REQ-031 Single request, no stall: iREQ_VALID=001, REG0=7, DATA0=0xDEADBEEF -> oREQ_READY=001 in the same cycle; next cycle oWB_VALID=1, oWB_REG=7, oWB_DATA=0xDEADBEEF; oWB_COUNT=1 after that edge.
REQ-032 All requesters valid continuously, no stall, from reset -> grants in the order 0,1,2,0,1,2 on consecutive cycles, with oWB_VALID high every cycle after the first.
REQ-033 Stall hold: a writeback is pending with REG=3, then iWB_STALL=1 for 4 cycles while iREQ_VALID=110 -> oREQ_READY=000 during the stall and oWB_REG stays 3; the cycle iWB_STALL falls, requester 1 is granted.
REQ-034 Collision: iREQ_VALID=011 with REG0=REG1=9 -> oDUP_ERR=1 on the next edge; requester 0 is granted, then requester 1 is granted the following cycle.
REQ-035 Counter wrap: preload 0xFFFF completed writebacks, then complete one more -> oWB_COUNT=0x0000.
REQ-036 Reset mid-stall: oWB_VALID=1 and iWB_STALL=1, then pulse iRST asynchronously -> oWB_VALID drops immediately and oWB_COUNT=0; after release, the first grant goes to the lowest-index valid requester.

Source files
------------

// File: rtl/gppcu_wb_arbiter_if.sv
// Writeback request/response bundle between the execution units, the
// writeback arbiter and the register-file write port. The signal names keep
// the arbiter's own i/o prefixes, so the slave modport reads like its port list.
interface gppcu_wb_arbiter_if #(
  parameter int NREQ  = 3,
  parameter int REGW  = 5,
  parameter int DATAW = 32
);
  logic [NREQ-1:0]       iREQ_VALID;
  logic [NREQ*REGW-1:0]  iREQ_REG;
  logic [NREQ*DATAW-1:0] iREQ_DATA;
  logic [NREQ-1:0]       oREQ_READY;
  logic                  iWB_STALL;
  logic                  oWB_VALID;
  logic [REGW-1:0]       oWB_REG;
  logic [DATAW-1:0]      oWB_DATA;
  logic [15:0]           oWB_COUNT;
  logic                  oDUP_ERR;

  // The arbiter itself.
  modport slave (
    input  iREQ_VALID, iREQ_REG, iREQ_DATA, iWB_STALL,
    output oREQ_READY, oWB_VALID, oWB_REG, oWB_DATA, oWB_COUNT, oDUP_ERR
  );

  // The requesters and the register file driving the arbiter.
  modport master (
    output iREQ_VALID, iREQ_REG, iREQ_DATA, iWB_STALL,
    input  oREQ_READY, oWB_VALID, oWB_REG, oWB_DATA, oWB_COUNT, oDUP_ERR
  );
endinterface

// File: rtl/gppcu_wb_arbiter.sv
// Round-robin writeback arbiter. NREQ execution units compete for a single
// register-file write port. The winner's index and data land in a one-entry
// output register. That register can be reloaded in the same cycle it drains,
// so the port can accept one writeback per cycle. The arbiter also counts
// completed writebacks and keeps a sticky flag for cycles where two valid
// requesters name the same destination register.
module gppcu_wb_arbiter #(
  parameter int NUMREG = 32,
  parameter int REGW   = 5,
  parameter int DATAW  = 32,
  parameter int NREQ   = 3
) (
  input  logic                 iACLK,
  input  logic                 iRST,
  gppcu_wb_arbiter_if.slave    bus
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // The index width must be able to address every architectural register.
  if (REGW < $clog2(NUMREG)) begin : g_bad_regw
    $error("gppcu_wb_arbiter: REGW too narrow for NUMREG");
  end

  logic [PTRW-1:0]  ptr_q, ptr_d;
  logic             wb_valid_q, wb_valid_d;
  logic [REGW-1:0]  wb_reg_q, wb_reg_d;
  logic [DATAW-1:0] wb_data_q, wb_data_d;
  logic [15:0]      wb_count_q, wb_count_d;
  logic             dup_err_q, dup_err_d;

  logic [NREQ-1:0]  grant;
  logic [PTRW-1:0]  grant_idx;
  logic             found;
  logic             stage_free;
  logic             xfer;
  logic             complete;
  logic             collision;

  // The output stage can take a new writeback when it is empty or draining.
  assign stage_free = !wb_valid_q || !bus.iWB_STALL;
  assign complete   = wb_valid_q && !bus.iWB_STALL;

  // Find the first valid requester, searching upward from the pointer and wrapping.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && bus.iREQ_VALID[(int'(ptr_q) + i) % NREQ]) begin
        found     = 1'b1;
        grant_idx = PTRW'((int'(ptr_q) + i) % NREQ);
        grant[(int'(ptr_q) + i) % NREQ] = 1'b1;
      end
    end
  end

  // Ready is forced low during reset so nothing appears to transfer then.
  assign bus.oREQ_READY = (stage_free && !iRST) ? grant : '0;
  assign xfer           = |bus.oREQ_READY;

  // Flag any two valid requesters that target the same destination register.
  always_comb begin
    collision = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = i + 1; j < NREQ; j++) begin
        if (bus.iREQ_VALID[i] && bus.iREQ_VALID[j] &&
            (bus.iREQ_REG[i*REGW +: REGW] == bus.iREQ_REG[j*REGW +: REGW])) begin
          collision = 1'b1;
        end
      end
    end
  end

  // Next-state: pointer advance, output-register load/drain, counter and sticky error.
  always_comb begin
    ptr_d      = ptr_q;
    wb_valid_d = wb_valid_q;
    wb_reg_d   = wb_reg_q;
    wb_data_d  = wb_data_q;
    wb_count_d = wb_count_q + 16'(complete);
    dup_err_d  = dup_err_q | collision;

    if (complete) begin
      wb_valid_d = 1'b0;
    end
    if (xfer) begin
      wb_valid_d = 1'b1;
      wb_reg_d   = bus.iREQ_REG[int'(grant_idx)*REGW +: REGW];
      wb_data_d  = bus.iREQ_DATA[int'(grant_idx)*DATAW +: DATAW];
      ptr_d      = (grant_idx == PTRW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // State registers; reset drops any pending writeback without completing it.
  always_ff @(posedge iACLK or posedge iRST) begin
    if (iRST) begin
      ptr_q      <= '0;
      wb_valid_q <= 1'b0;
      // NOTE: the payload registers are reset too, because oWB_REG and
      // oWB_DATA are observable and must read zero while reset is held.
      wb_reg_q   <= '0;
      wb_data_q  <= '0;
      wb_count_q <= '0;
      dup_err_q  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so that every
      // register samples the pre-edge values computed by the comb block.
      ptr_q      <= ptr_d;
      wb_valid_q <= wb_valid_d;
      wb_reg_q   <= wb_reg_d;
      wb_data_q  <= wb_data_d;
      wb_count_q <= wb_count_d;
      dup_err_q  <= dup_err_d;
    end
  end

  assign bus.oWB_VALID = wb_valid_q;
  assign bus.oWB_REG   = wb_reg_q;
  assign bus.oWB_DATA  = wb_data_q;
  assign bus.oWB_COUNT = wb_count_q;
  assign bus.oDUP_ERR  = dup_err_q;

endmodule

// File: tb/tb_gppcu_wb_arbiter.sv
// Directed bench for the writeback arbiter. Inputs change 1 ns after a rising
// edge. Combinational ready is sampled at +2 ns, and registered outputs are
// sampled at +1 ns after the edge that loads them.
module tb_gppcu_wb_arbiter;

  localparam int NREQ  = 3;
  localparam int REGW  = 5;
  localparam int DATAW = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  gppcu_wb_arbiter_if #(.NREQ(NREQ), .REGW(REGW), .DATAW(DATAW)) bus ();

  gppcu_wb_arbiter #(.NUMREG(32), .REGW(REGW), .DATAW(DATAW), .NREQ(NREQ)) dut (
    .iACLK (clk),
    .iRST  (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input int k, input logic [REGW-1:0] r, input logic [DATAW-1:0] d);
    bus.iREQ_REG[k*REGW +: REGW]    = r;
    bus.iREQ_DATA[k*DATAW +: DATAW] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.iREQ_VALID = 3'b111;
    bus.iWB_STALL  = 1'b0;
    repeat (2) step();
    #1;
    n_checks++;
    if (bus.oREQ_READY !== 3'b000) begin n_fail++; $display("FAIL reset_ready: got %b expected 000", bus.oREQ_READY); end
    n_checks++;
    if (bus.oWB_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.oWB_VALID); end
    n_checks++;
    if (bus.oWB_COUNT !== 16'h0000 || bus.oDUP_ERR !== 1'b0) begin
      n_fail++; $display("FAIL reset_count_dup: got %h/%b expected 0000/0", bus.oWB_COUNT, bus.oDUP_ERR);
    end
    n_checks++;
    if (bus.oWB_REG !== 5'd0 || bus.oWB_DATA !== 32'h0) begin
      n_fail++; $display("FAIL reset_payload: got %h/%h expected 00/00000000", bus.oWB_REG, bus.oWB_DATA);
    end
    bus.iREQ_VALID = 3'b000;
    step();
    rst = 1'b0;
  endtask

  task automatic test_single();
    step();
    set_req(0, 5'd7, 32'hDEADBEEF);
    bus.iREQ_VALID = 3'b001;
    #1;
    n_checks++;
    if (bus.oREQ_READY !== 3'b001) begin n_fail++; $display("FAIL single_ready: got %b expected 001", bus.oREQ_READY); end
    step();
    bus.iREQ_VALID = 3'b000;
    n_checks++;
    if (bus.oWB_VALID !== 1'b1 || bus.oWB_REG !== 5'd7 || bus.oWB_DATA !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL single_load: got %b/%0d/%h expected 1/7/deadbeef", bus.oWB_VALID, bus.oWB_REG, bus.oWB_DATA);
    end
    step();
    n_checks++;
    if (bus.oWB_COUNT !== 16'd1 || bus.oWB_VALID !== 1'b0) begin
      n_fail++; $display("FAIL single_complete: got count %0d valid %b expected 1/0", bus.oWB_COUNT, bus.oWB_VALID);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_ready [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    int         exp_reg   [6] = '{10, 11, 12, 10, 11, 12};
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
    for (int k = 0; k < NREQ; k++) set_req(k, REGW'(10 + k), DATAW'(32'h100 + k));
    bus.iREQ_VALID = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++;
      if (bus.oREQ_READY !== exp_ready[c]) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", c, bus.oREQ_READY, exp_ready[c]);
      end
      if (c > 0) begin
        n_checks++;
        if (bus.oWB_VALID !== 1'b1 || bus.oWB_REG !== REGW'(exp_reg[c-1])) begin
          n_fail++; $display("FAIL rr_out[%0d]: got %b/%0d expected 1/%0d", c, bus.oWB_VALID, bus.oWB_REG, exp_reg[c-1]);
        end
      end
      step();
    end
    bus.iREQ_VALID = 3'b000;
    n_checks++;
    if (bus.oWB_REG !== 5'd12 || bus.oWB_DATA !== 32'h102) begin
      n_fail++; $display("FAIL rr_last: got %0d/%h expected 12/00000102", bus.oWB_REG, bus.oWB_DATA);
    end
    step();
    n_checks++;
    if (bus.oWB_COUNT !== 16'd6) begin n_fail++; $display("FAIL rr_count: got %0d expected 6", bus.oWB_COUNT); end
  endtask

  task automatic test_stall();
    set_req(0, 5'd3, 32'h33);
    set_req(1, 5'd20, 32'h2020);
    set_req(2, 5'd21, 32'h2121);
    bus.iREQ_VALID = 3'b001;
    step();
    bus.iWB_STALL  = 1'b1;
    bus.iREQ_VALID = 3'b110;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (bus.oREQ_READY !== 3'b000 || bus.oWB_VALID !== 1'b1 || bus.oWB_REG !== 5'd3) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got ready %b valid %b reg %0d expected 000/1/3",
                           c, bus.oREQ_READY, bus.oWB_VALID, bus.oWB_REG);
      end
      step();
    end
    bus.iWB_STALL = 1'b0;
    #1;
    n_checks++;
    if (bus.oREQ_READY !== 3'b010) begin n_fail++; $display("FAIL stall_release_grant: got %b expected 010", bus.oREQ_READY); end
    step();
    bus.iREQ_VALID = 3'b000;
    n_checks++;
    if (bus.oWB_REG !== 5'd20 || bus.oWB_DATA !== 32'h2020 || bus.oWB_COUNT !== 16'd7) begin
      n_fail++; $display("FAIL stall_reload: got %0d/%h count %0d expected 20/00002020 count 7",
                         bus.oWB_REG, bus.oWB_DATA, bus.oWB_COUNT);
    end
    step();
    n_checks++;
    if (bus.oWB_COUNT !== 16'd8) begin n_fail++; $display("FAIL stall_count: got %0d expected 8", bus.oWB_COUNT); end
  endtask

  task automatic test_collision();
    set_req(0, 5'd9, 32'hA0);
    set_req(1, 5'd9, 32'hA1);
    bus.iREQ_VALID = 3'b011;
    #1;
    n_checks++;
    if (bus.oREQ_READY !== 3'b001 || bus.oDUP_ERR !== 1'b0) begin
      n_fail++; $display("FAIL dup_first: got ready %b dup %b expected 001/0", bus.oREQ_READY, bus.oDUP_ERR);
    end
    step();
    bus.iREQ_VALID = 3'b010;
    #1;
    n_checks++;
    if (bus.oDUP_ERR !== 1'b1 || bus.oREQ_READY !== 3'b010 || bus.oWB_DATA !== 32'hA0) begin
      n_fail++; $display("FAIL dup_second: got dup %b ready %b data %h expected 1/010/000000a0",
                         bus.oDUP_ERR, bus.oREQ_READY, bus.oWB_DATA);
    end
    step();
    bus.iREQ_VALID = 3'b000;
    n_checks++;
    if (bus.oWB_DATA !== 32'hA1) begin n_fail++; $display("FAIL dup_data: got %h expected 000000a1", bus.oWB_DATA); end
    step();
    n_checks++;
    if (bus.oDUP_ERR !== 1'b1 || bus.oWB_COUNT !== 16'd10) begin
      n_fail++; $display("FAIL dup_sticky: got dup %b count %0d expected 1/10", bus.oDUP_ERR, bus.oWB_COUNT);
    end
  endtask

  task automatic test_reset_mid_stall();
    set_req(0, 5'd5, 32'h55);
    set_req(1, 5'd17, 32'h1717);
    bus.iREQ_VALID = 3'b001;
    step();
    bus.iREQ_VALID = 3'b000;
    bus.iWB_STALL  = 1'b1;
    n_checks++;
    if (bus.oWB_VALID !== 1'b1 || bus.oWB_REG !== 5'd5) begin
      n_fail++; $display("FAIL rst_stall_pending: got %b/%0d expected 1/5", bus.oWB_VALID, bus.oWB_REG);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.oWB_VALID !== 1'b0 || bus.oWB_COUNT !== 16'd0 || bus.oDUP_ERR !== 1'b0) begin
      n_fail++; $display("FAIL rst_async: got valid %b count %0d dup %b expected 0/0/0",
                         bus.oWB_VALID, bus.oWB_COUNT, bus.oDUP_ERR);
    end
    #1;
    rst = 1'b0;
    bus.iWB_STALL = 1'b0;
    step();
    bus.iREQ_VALID = 3'b110;
    #1;
    n_checks++;
    if (bus.oREQ_READY !== 3'b010) begin n_fail++; $display("FAIL rst_first_grant: got %b expected 010", bus.oREQ_READY); end
    step();
    bus.iREQ_VALID = 3'b000;
    n_checks++;
    if (bus.oWB_REG !== 5'd17 || bus.oWB_COUNT !== 16'd0) begin
      n_fail++; $display("FAIL rst_first_load: got %0d count %0d expected 17/0", bus.oWB_REG, bus.oWB_COUNT);
    end
    step();
  endtask

  task automatic test_count_wrap();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
    bus.iREQ_VALID = 3'b111;
    repeat (65535) @(posedge clk);
    #1;
    bus.iREQ_VALID = 3'b000;
    step();
    n_checks++;
    if (bus.oWB_COUNT !== 16'hFFFF || bus.oWB_VALID !== 1'b0) begin
      n_fail++; $display("FAIL wrap_preload: got %h valid %b expected ffff/0", bus.oWB_COUNT, bus.oWB_VALID);
    end
    bus.iREQ_VALID = 3'b100;
    step();
    bus.iREQ_VALID = 3'b000;
    step();
    n_checks++;
    if (bus.oWB_COUNT !== 16'h0000) begin n_fail++; $display("FAIL wrap: got %h expected 0000", bus.oWB_COUNT); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.iREQ_VALID = '0;
    bus.iREQ_REG   = '0;
    bus.iREQ_DATA  = '0;
    bus.iWB_STALL  = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_collision();
    test_reset_mid_stall();
    test_count_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
